uart_frame_rx: RTL and testbench

Parametrised UART receiver and frame unpacker for the sensor/fan-control link. It deserialises 8-bit UART characters and optionally checks parity. It can hunt for a sync byte, then assembles BYTES_PER_FRAME payload bytes, least-significant byte first, into one OUT_WIDTH-bit word. It reports errors and inter-byte timeouts, and feeds the temperature/duty decode logic downstream.

---
 rtl/uart_frame_rx.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_rx
// Description : UART receiver (8 data bits, optional parity) with optional
//               sync-byte hunting, multi-byte frame assembly (LSB first),
//               error and inter-byte timeout reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_rx #(
    parameter int          UART_BPS        = 115200,
    parameter int          CLK_FREQ        = 50_000_000,
    parameter int          BYTES_PER_FRAME = 2,
    parameter int          OUT_WIDTH       = 13,
    parameter int          PARITY          = 0,
    parameter int          SYNC_EN         = 0,
    parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
    parameter int          TIMEOUT_BITS    = 20
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx,
    output logic [OUT_WIDTH-1:0] frame_data,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 timeout
);

    localparam int c_BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int c_CNT_W        = $clog2(c_BAUD_CNT_MAX);
    localparam int c_SAMPLE       = c_BAUD_CNT_MAX / 2 - 1;
    localparam int c_GAP_MAX      = TIMEOUT_BITS * c_BAUD_CNT_MAX;
    localparam int c_GAP_W        = $clog2(c_GAP_MAX);
    localparam int c_IDX_W        = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
    localparam int c_PAY_W        = 8 * BYTES_PER_FRAME;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BYTES_PER_FRAME - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } bit_state_t;

    typedef enum logic [0:0] {
        F_HUNT    = 1'b0,
        F_PAYLOAD = 1'b1
    } frame_state_t;

    // Where the frame tracker lands after a frame ends or is abandoned
    localparam frame_state_t c_FRAME_RST = (SYNC_EN != 0) ? F_HUNT : F_PAYLOAD;

    // Line synchroniser and edge detect
    logic r_rx_meta, r_rx_sync, r_rx_prev;
    logic w_rx, w_fall;

    // Bit-level receiver
    bit_state_t           r_bit_st, w_bit_st_nxt;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_par_bit;
    logic                 w_sample, w_byte_done, w_par_fail;

    // Frame-level tracker
    frame_state_t         r_frame_st, w_frame_st_nxt;
    logic [c_IDX_W-1:0]   r_byte_idx, w_byte_idx_nxt;
    logic [c_PAY_W-1:0]   r_payload, w_assembled;
    logic                 w_load_payload, w_load_data;
    logic                 w_valid_nxt, w_perr_nxt, w_ferr_nxt, w_tout_nxt;

    // Inter-byte gap watchdog
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic                 w_gap_run, w_gap_hit;

    assign w_rx     = r_rx_sync;
    assign w_fall   = r_rx_prev & ~r_rx_sync;
    assign w_sample = (r_baud_cnt == c_CNT_W'(c_SAMPLE));

    // Parity bit is only consulted when parity is enabled
    always_comb begin
        w_par_fail = 1'b0;
        if (PARITY == 1) begin
            w_par_fail = ~(^{r_shift, r_par_bit});
        end else if (PARITY == 2) begin
            w_par_fail = ^{r_shift, r_par_bit};
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Bit FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bit_st <= S_IDLE;
        end else begin
            r_bit_st <= w_bit_st_nxt;
        end
    end

    // Bit FSM next state; stop leaves at mid-bit to tolerate back-to-back bytes
    always_comb begin
        w_bit_st_nxt = r_bit_st;
        w_byte_done  = 1'b0;
        case (r_bit_st)
            S_IDLE: begin
                if (w_fall) begin
                    w_bit_st_nxt = S_START;
                end
            end
            S_START: begin
                if (w_sample) begin
                    w_bit_st_nxt = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_sample && (r_bit_idx == 3'd7)) begin
                    w_bit_st_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_sample) begin
                    w_bit_st_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    w_bit_st_nxt = S_IDLE;
                    w_byte_done  = 1'b1;
                end
            end
            default: w_bit_st_nxt = S_IDLE;
        endcase
    end

    // Baud counter and data/parity shift path; counter parked at zero in idle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_bit  <= 1'b0;
        end else if (r_bit_st == S_IDLE) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
        end else begin
            r_baud_cnt <= (r_baud_cnt == c_CNT_W'(c_BAUD_CNT_MAX - 1)) ? '0 : r_baud_cnt + 1'b1;
            if (w_sample && (r_bit_st == S_DATA)) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_sample && (r_bit_st == S_PARITY)) begin
                r_par_bit <= w_rx;
            end
        end
    end

    // Payload with the just-received byte dropped into its lane
    always_comb begin
        w_assembled = r_payload;
        for (int i = 0; i < BYTES_PER_FRAME; i++) begin
            if (r_byte_idx == c_IDX_W'(i)) begin
                w_assembled[i*8 +: 8] = r_shift;
            end
        end
    end

    // Gap watchdog runs only while a partial frame is outstanding
    assign w_gap_run = (r_bit_st == S_IDLE) &&
                       ((r_byte_idx != '0) || ((SYNC_EN != 0) && (r_frame_st == F_PAYLOAD)));
    assign w_gap_hit = w_gap_run && !w_fall && (r_gap_cnt == c_GAP_W'(c_GAP_MAX - 1));

    // Gap counter: cleared by any falling edge or whenever no frame is pending
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_gap_cnt <= '0;
        end else if (w_fall || !w_gap_run || w_gap_hit) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // Frame tracker next state; errors beat data, frame_err beats parity_err
    always_comb begin
        w_frame_st_nxt = r_frame_st;
        w_byte_idx_nxt = r_byte_idx;
        w_load_payload = 1'b0;
        w_load_data    = 1'b0;
        w_valid_nxt    = 1'b0;
        w_perr_nxt     = 1'b0;
        w_ferr_nxt     = 1'b0;
        w_tout_nxt     = 1'b0;
        if (w_byte_done) begin
            if (!w_rx) begin
                w_ferr_nxt     = 1'b1;
                w_byte_idx_nxt = '0;
                w_frame_st_nxt = c_FRAME_RST;
            end else if (w_par_fail) begin
                w_perr_nxt     = 1'b1;
                w_byte_idx_nxt = '0;
                w_frame_st_nxt = c_FRAME_RST;
            end else if (r_frame_st == F_HUNT) begin
                if (r_shift == SYNC_BYTE) begin
                    w_frame_st_nxt = F_PAYLOAD;
                    w_byte_idx_nxt = '0;
                end
            end else begin
                w_load_payload = 1'b1;
                if (r_byte_idx == c_LAST_IDX) begin
                    w_load_data    = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_byte_idx_nxt = '0;
                    w_frame_st_nxt = c_FRAME_RST;
                end else begin
                    w_byte_idx_nxt = r_byte_idx + c_IDX_W'(1);
                end
            end
        end else if (w_gap_hit) begin
            w_tout_nxt     = 1'b1;
            w_byte_idx_nxt = '0;
            w_frame_st_nxt = c_FRAME_RST;
        end
    end

    // Frame tracker registers and registered output pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_st  <= c_FRAME_RST;
            r_byte_idx  <= '0;
            r_payload   <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_frame_st  <= w_frame_st_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            if (w_load_payload) begin
                r_payload <= w_assembled;
            end
            if (w_load_data) begin
                frame_data <= w_assembled[OUT_WIDTH-1:0];
            end
            frame_valid <= w_valid_nxt;
            parity_err  <= w_perr_nxt;
            frame_err   <= w_ferr_nxt;
            timeout     <= w_tout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_frame_rx
// Description : Self-checking bench for uart_frame_rx: three instances
//               (8N1, even parity, sync-byte mode) with a frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

    localparam int CLK_FREQ = 25_600_000;
    localparam int UART_BPS = 100_000;
    localparam int BIT_CLKS = CLK_FREQ / UART_BPS;   // 256 clocks per bit

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rx_def = 1'b1, rx_par = 1'b1, rx_syn = 1'b1;
    logic [12:0] fd_def, fd_par, fd_syn;
    logic        fv_def, pe_def, fe_def, to_def;
    logic        fv_par, pe_par, fe_par, to_par;
    logic        fv_syn, pe_syn, fe_syn, to_syn;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_fv[3], cnt_pe[3], cnt_fe[3], cnt_to[3];

    logic [12:0] q_def[$], q_par[$], q_syn[$];
    logic [12:0] exp_def, exp_par, exp_syn;

    always #5 sys_clk = ~sys_clk;

    uart_frame_rx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) u_def (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_def),
        .frame_data(fd_def), .frame_valid(fv_def), .parity_err(pe_def),
        .frame_err(fe_def), .timeout(to_def));

    uart_frame_rx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .PARITY(2)) u_par (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_par),
        .frame_data(fd_par), .frame_valid(fv_par), .parity_err(pe_par),
        .frame_err(fe_par), .timeout(to_par));

    uart_frame_rx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .SYNC_EN(1)) u_syn (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_syn),
        .frame_data(fd_syn), .frame_valid(fv_syn), .parity_err(pe_syn),
        .frame_err(fe_syn), .timeout(to_syn));

    // Scoreboard monitors: pop an expected word on every frame_valid
    always @(negedge sys_clk) begin
        if (fv_def) begin
            cnt_fv[0]++;
            n_tests++;
            if (q_def.size() == 0) begin
                n_fail++;
                $display("FAIL def_unexpected_valid: frame_data=%h, no frame expected", fd_def);
            end else begin
                exp_def = q_def.pop_front();
                if (fd_def !== exp_def) begin
                    n_fail++;
                    $display("FAIL def_frame_data: got %h, expected %h", fd_def, exp_def);
                end
            end
            if (pe_def || fe_def || to_def) begin
                n_fail++;
                $display("FAIL def_exclusive: valid with error pe=%b fe=%b to=%b, expected none", pe_def, fe_def, to_def);
            end
        end
        if (pe_def) cnt_pe[0]++;
        if (fe_def) cnt_fe[0]++;
        if (to_def) cnt_to[0]++;
    end

    always @(negedge sys_clk) begin
        if (fv_par) begin
            cnt_fv[1]++;
            n_tests++;
            if (q_par.size() == 0) begin
                n_fail++;
                $display("FAIL par_unexpected_valid: frame_data=%h, no frame expected", fd_par);
            end else begin
                exp_par = q_par.pop_front();
                if (fd_par !== exp_par) begin
                    n_fail++;
                    $display("FAIL par_frame_data: got %h, expected %h", fd_par, exp_par);
                end
            end
        end
        if (pe_par && fe_par) begin
            n_fail++;
            $display("FAIL par_both_errors: pe=1 fe=1, expected at most one");
        end
        if (pe_par) cnt_pe[1]++;
        if (fe_par) cnt_fe[1]++;
        if (to_par) cnt_to[1]++;
    end

    always @(negedge sys_clk) begin
        if (fv_syn) begin
            cnt_fv[2]++;
            n_tests++;
            if (q_syn.size() == 0) begin
                n_fail++;
                $display("FAIL syn_unexpected_valid: frame_data=%h, no frame expected", fd_syn);
            end else begin
                exp_syn = q_syn.pop_front();
                if (fd_syn !== exp_syn) begin
                    n_fail++;
                    $display("FAIL syn_frame_data: got %h, expected %h", fd_syn, exp_syn);
                end
            end
        end
        if (pe_syn) cnt_pe[2]++;
        if (fe_syn) cnt_fe[2]++;
        if (to_syn) cnt_to[2]++;
    end

    task automatic drive(input int dut, input logic v);
        case (dut)
            0:       rx_def = v;
            1:       rx_par = v;
            default: rx_syn = v;
        endcase
    endtask

    task automatic hold_bits(input int n);
        repeat (n * BIT_CLKS) @(negedge sys_clk);
    endtask

    task automatic send_byte(input int dut, input logic [7:0] b, input bit use_par,
                             input logic par, input logic stop);
        drive(dut, 1'b0);
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(dut, b[i]);
            hold_bits(1);
        end
        if (use_par) begin
            drive(dut, par);
            hold_bits(1);
        end
        drive(dut, stop);
        hold_bits(1);
        drive(dut, 1'b1);
    endtask

    task automatic send_plain(input int dut, input logic [7:0] b);
        send_byte(dut, b, 1'b0, 1'b0, 1'b1);
    endtask

    // Even parity: parity bit makes the total count of ones even
    task automatic send_even(input int dut, input logic [7:0] b, input bit good);
        logic p;
        p = ^b;
        if (!good) p = ~p;
        send_byte(dut, b, 1'b1, p, 1'b1);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if ({fd_def, fd_par, fd_syn} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_frame_data: got %h/%h/%h, expected 0", fd_def, fd_par, fd_syn);
        end
        n_tests++;
        if ({fv_def, pe_def, fe_def, to_def} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 0000", {fv_def, pe_def, fe_def, to_def});
        end
        sys_rst_n = 1'b1;
        hold_bits(1);
    endtask

    task automatic test_basic;
        int fv0, err0;
        fv0  = cnt_fv[0];
        err0 = cnt_pe[0] + cnt_fe[0] + cnt_to[0];
        q_def.push_back(13'h1234);
        send_plain(0, 8'h34);
        send_plain(0, 8'h12);
        hold_bits(1);
        check_int("basic_pending", q_def.size(), 0);
        check_int("basic_valid_count", cnt_fv[0] - fv0, 1);
        check_int("basic_err_count", cnt_pe[0] + cnt_fe[0] + cnt_to[0] - err0, 0);
        n_tests++;
        if (fd_def !== 13'h1234) begin
            n_fail++;
            $display("FAIL basic_hold: got %h, expected 1234", fd_def);
        end
    endtask

    task automatic test_glitch;
        int ev0;
        ev0 = cnt_fv[0] + cnt_pe[0] + cnt_fe[0] + cnt_to[0];
        drive(0, 1'b0);
        repeat (100) @(negedge sys_clk);
        drive(0, 1'b1);
        hold_bits(3);
        check_int("glitch_no_pulse", cnt_fv[0] + cnt_pe[0] + cnt_fe[0] + cnt_to[0] - ev0, 0);
        q_def.push_back(13'h1234);
        send_plain(0, 8'h34);
        send_plain(0, 8'h12);
        hold_bits(1);
        check_int("glitch_pending", q_def.size(), 0);
    endtask

    task automatic test_frame_err;
        int fv0, fe0;
        fv0 = cnt_fv[0];
        fe0 = cnt_fe[0];
        send_byte(0, 8'h34, 1'b0, 1'b0, 1'b0);
        hold_bits(2);
        check_int("ferr_pulse", cnt_fe[0] - fe0, 1);
        check_int("ferr_no_valid", cnt_fv[0] - fv0, 0);
        q_def.push_back(13'h0578);
        send_plain(0, 8'h78);
        send_plain(0, 8'h05);
        hold_bits(1);
        check_int("ferr_pending", q_def.size(), 0);
        check_int("ferr_single", cnt_fe[0] - fe0, 1);
    endtask

    task automatic test_timeout;
        int to0;
        to0 = cnt_to[0];
        send_plain(0, 8'h34);
        hold_bits(25);
        check_int("timeout_pulse", cnt_to[0] - to0, 1);
        q_def.push_back(13'h0256);
        send_plain(0, 8'h56);
        send_plain(0, 8'h02);
        hold_bits(1);
        check_int("timeout_pending", q_def.size(), 0);
        check_int("timeout_single", cnt_to[0] - to0, 1);
    endtask

    // 0x34 holds three ones, so the correct even-parity bit is 1
    task automatic test_parity;
        int pe0, fv0, fe0;
        pe0 = cnt_pe[1];
        fv0 = cnt_fv[1];
        fe0 = cnt_fe[1];
        send_even(1, 8'h34, 1'b0);
        hold_bits(1);
        check_int("parity_pulse", cnt_pe[1] - pe0, 1);
        check_int("parity_no_valid", cnt_fv[1] - fv0, 0);
        q_par.push_back(13'h1234);
        send_even(1, 8'h34, 1'b1);
        send_even(1, 8'h12, 1'b1);
        hold_bits(1);
        check_int("parity_pending", q_par.size(), 0);
        check_int("parity_single", cnt_pe[1] - pe0, 1);
        check_int("parity_no_ferr", cnt_fe[1] - fe0, 0);
    endtask

    task automatic test_sync;
        int fv0;
        fv0 = cnt_fv[2];
        q_syn.push_back(13'h0178);
        send_plain(2, 8'h00);
        send_plain(2, 8'hA5);
        send_plain(2, 8'h78);
        send_plain(2, 8'h01);
        hold_bits(1);
        check_int("sync_pending", q_syn.size(), 0);
        check_int("sync_valid_count", cnt_fv[2] - fv0, 1);
        send_plain(2, 8'h11);
        send_plain(2, 8'h22);
        hold_bits(1);
        check_int("sync_no_resync_valid", cnt_fv[2] - fv0, 1);
        n_tests++;
        if (fd_syn !== 13'h0178) begin
            n_fail++;
            $display("FAIL sync_hold: got %h, expected 0178", fd_syn);
        end
    endtask

    task automatic test_reset_mid;
        send_plain(0, 8'h34);
        drive(0, 1'b0);
        hold_bits(1);
        drive(0, 1'b1);
        hold_bits(2);
        #3;
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if (fd_def !== 13'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_data: got %h, expected 0000", fd_def);
        end
        n_tests++;
        if ({fv_def, pe_def, fe_def, to_def} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid_flags: got %b, expected 0000", {fv_def, pe_def, fe_def, to_def});
        end
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        hold_bits(2);
        q_def.push_back(13'h1234);
        send_plain(0, 8'h34);
        send_plain(0, 8'h12);
        hold_bits(1);
        check_int("reset_mid_pending", q_def.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cnt_fv[i] = 0;
            cnt_pe[i] = 0;
            cnt_fe[i] = 0;
            cnt_to[i] = 0;
        end
        test_reset();
        fork
            begin
                test_basic();
                test_glitch();
                test_frame_err();
                test_timeout();
            end
            test_parity();
            test_sync();
        join
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
